reg_native_arb: RTL and testbench
=================================

# reg_native_arb

Round-robin arbiter that shares one downstream reg_native_if, such as the upstream port of a generated regslv block, between N upstream masters. It keeps one transaction outstanding at a time and latches the winning master's command. It forwards the command downstream, collects the acknowledge, and returns it only to the master that issued it. An optional acknowledge timeout returns a fixed error word so a hung slave cannot lock the bus.

## Interface
- N_MASTER, 3: number of upstream masters (≥2)
- ADDR_WIDTH, 64: address width
- DATA_WIDTH, 32: data width
- TIMEOUT_CYCLES, 256: WAIT-state cycles before a forced ack; 0 disables the timeout
- TIMEOUT_DATA, 32'hDEAD_BEEF: rd_data returned on timeout (DATA_WIDTH wide)

Ports. Per-master buses are flattened; master i occupies slice i.

- clk  in  1  single clock; everything is synchronous to its rising edge
- srst  in  1  synchronous reset, active high
- m_req_vld  in  N_MASTER  request valid, per master
- m_req_rdy  out  N_MASTER  request accepted (one-hot or zero)
- m_wr_en, m_rd_en  in  N_MASTER each  per-master command
- m_addr  in  N_MASTER*ADDR_WIDTH  per-master address
- m_wr_data  in  N_MASTER*DATA_WIDTH  per-master write data
- m_ack_vld  out  N_MASTER  acknowledge valid (one-hot or zero)
- m_ack_rdy  in  N_MASTER  acknowledge ready, per master
- m_rd_data  out  DATA_WIDTH  read data, shared and meaningful only with m_ack_vld
- m_err  out  1  high with m_ack_vld when the ack was produced by timeout
- s_req_vld  out  1  downstream request valid
- s_req_rdy  in  1  downstream request ready
- s_wr_en, s_rd_en  out  1  downstream command
- s_addr  out  ADDR_WIDTH  downstream address
- s_wr_data  out  DATA_WIDTH  downstream write data
- s_ack_vld  in  1  downstream acknowledge valid
- s_ack_rdy  out  1  downstream acknowledge ready
- s_rd_data  in  DATA_WIDTH  downstream read data
- busy  out  1  high in any state other than IDLE

## Operation
- Handshake rule: a beat transfers on the rising edge where vld and rdy are both high. A master holds its vld and command fields stable until that beat.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: if any m_req_vld is set, the rr_arbiter picks a winner g and drives m_req_rdy[g]=1 combinationally in the same cycle.
  - On that edge: latch g, wr_en, rd_en, addr and wr_data into registers; update the priority pointer to g+1 mod N_MASTER; go to REQ.
- REQ: s_req_vld=1 and s_* are driven from the registers. When s_req_rdy=1, go to WAIT and clear the timeout counter.
- WAIT: s_ack_rdy=1.
  - If s_ack_vld=1: capture s_rd_data, set err=0, go to RESP.
  - Else, if TIMEOUT_CYCLES≠0 and the counter has reached TIMEOUT_CYCLES-1: load TIMEOUT_DATA, set err=1, go to RESP.
  - Otherwise increment the counter.
- RESP: m_ack_vld[g]=1 and m_rd_data/m_err come from registers. When m_ack_rdy[g]=1, go to IDLE. The ack_rdy of other masters is ignored.
- Round-robin: search starts at the pointer and wraps at N_MASTER-1 → 0. The pointer resets to 0 and only moves on a grant.
- A request with both wr_en and rd_en low is forwarded unchanged; the block does not interpret commands.
- Arbiter output requirements: m_req_rdy and m_ack_vld are never multi-hot; s_req_vld is never dropped before s_req_rdy.

## Timing
- Reset values: state=IDLE, pointer=0, s_req_vld=0, s_ack_rdy=0, m_req_rdy=0, m_ack_vld=0, m_rd_data=0, m_err=0, busy=0, s_addr/s_wr_data/s_wr_en/s_rd_en=0.
- Minimum transaction: accept edge → REQ (1 cycle if s_req_rdy=1) → WAIT (1 cycle if s_ack_vld=1) → RESP (1 cycle if ack_rdy=1) → IDLE. That is 4 cycles from m_req_rdy to the next possible m_req_rdy.
- m_req_rdy is combinational from m_req_vld in IDLE only. All s_* outputs and m_ack_vld are registered-state decodes.
- Timeout: a forced ack appears TIMEOUT_CYCLES cycles after the WAIT entry edge. If s_ack_vld arrives in the same cycle as expiry, the real ack wins (err=0).
- A late s_ack_vld after a timeout is not accepted (s_ack_rdy=0 outside WAIT). The downstream slave must tolerate this.
- srst asserted in any state returns to IDLE on the next edge and discards the transaction; no ack is issued.
- Simultaneous requests: the highest-priority requester wins. Others keep vld high and are served in later arbitrations.

## Structure
- Package reg_native_arb_pkg: state enum (IDLE, REQ, WAIT, RESP) and a default TIMEOUT_DATA constant.
- Sub-module rr_arbiter (params N; inputs req[N], ptr, en; output gnt one-hot): purely combinational priority rotation. The pointer register stays in reg_native_arb.
- The command/data latch, timeout counter ($clog2(TIMEOUT_CYCLES+1) bits) and FSM are in the top level.

## Test plan
- Single write, N=3, all downstream ready/ack=1: master 1 writes addr 0x200, data 0xFFFFFFFF → s_addr=0x200 one cycle after accept; m_ack_vld[1] 3 cycles after accept; busy drops after m_ack_rdy.
- All three masters request at once, each held until accepted: grants go 0,1,2 → next round 0,1,2. Pointer wrap 2→0 verified, no multi-hot rdy/ack.
- Read with 5-cycle slave ack delay and s_rd_data=0x1234_5678: m_rd_data=0x1234_5678, m_err=0, ack routed only to the granted master.
- TIMEOUT_CYCLES=8, slave never acks → m_ack_vld after 8 WAIT cycles with rd_data=0xDEADBEEF, m_err=1. A second run with the ack on the expiry cycle gives err=0 and the slave data.
- srst pulsed during WAIT → next cycle IDLE, s_ack_rdy=0, no m_ack_vld; a following transaction completes normally.
- Backpressure: m_ack_rdy held low for 10 cycles → m_ack_vld and m_rd_data stay stable, and no new m_req_rdy is given to any master.

Source files
------------

// File: rtl/reg_native_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_native_arb_pkg
//  Description : Shared FSM state encoding and default constants for the
//                reg_native round-robin arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_native_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    localparam logic [31:0] C_TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/reg_native_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant; search starts at ptr and
//                wraps, producing a one-hot (or zero) grant when enabled.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt
);

    int   w_idx;
    logic w_found;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (en && !w_found && req[w_idx[PTR_W-1:0]]) begin
                gnt[w_idx[PTR_W-1:0]] = 1'b1;
                w_found               = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_native_arb.sv
`default_nettype none
// ============================================================================
//  Module      : reg_native_arb
//  Description : Shares one downstream reg_native port between N masters with
//                round-robin arbitration, single outstanding transaction and
//                an optional acknowledge timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_native_arb
    import reg_native_arb_pkg::*;
#(
    parameter int                    N_MASTER       = 3,
    parameter int                    ADDR_WIDTH     = 64,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 256,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = DATA_WIDTH'(C_TIMEOUT_DATA_DEFAULT)
) (
    input  logic                           clk,
    input  logic                           srst,
    input  logic [N_MASTER-1:0]            m_req_vld,
    output logic [N_MASTER-1:0]            m_req_rdy,
    input  logic [N_MASTER-1:0]            m_wr_en,
    input  logic [N_MASTER-1:0]            m_rd_en,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] m_addr,
    input  logic [N_MASTER*DATA_WIDTH-1:0] m_wr_data,
    output logic [N_MASTER-1:0]            m_ack_vld,
    input  logic [N_MASTER-1:0]            m_ack_rdy,
    output logic [DATA_WIDTH-1:0]          m_rd_data,
    output logic                           m_err,
    output logic                           s_req_vld,
    input  logic                           s_req_rdy,
    output logic                           s_wr_en,
    output logic                           s_rd_en,
    output logic [ADDR_WIDTH-1:0]          s_addr,
    output logic [DATA_WIDTH-1:0]          s_wr_data,
    input  logic                           s_ack_vld,
    output logic                           s_ack_rdy,
    input  logic [DATA_WIDTH-1:0]          s_rd_data,
    output logic                           busy
);

    localparam int c_PTR_W = $clog2(N_MASTER);
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST =
        (TIMEOUT_CYCLES > 0) ? c_CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [c_PTR_W-1:0]      r_ptr;
    logic [N_MASTER-1:0]     r_gnt;
    logic                    r_wr_en;
    logic                    r_rd_en;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wr_data;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_err;
    logic [c_CNT_W-1:0]      r_cnt;

    logic [N_MASTER-1:0]     w_gnt;
    logic [c_PTR_W-1:0]      w_gnt_idx;
    logic [c_PTR_W-1:0]      w_ptr_nxt;
    logic                    w_sel_wr_en;
    logic                    w_sel_rd_en;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wr_data;
    logic                    w_timeout;
    logic                    w_ack_done;

    rr_arbiter #(
        .N     (N_MASTER),
        .PTR_W (c_PTR_W)
    ) u_rr_arbiter (
        .req (m_req_vld),
        .ptr (r_ptr),
        .en  (r_state == ST_IDLE),
        .gnt (w_gnt)
    );

    // Winner index and its command fields, muxed from the flattened buses
    always_comb begin
        w_gnt_idx     = '0;
        w_sel_wr_en   = 1'b0;
        w_sel_rd_en   = 1'b0;
        w_sel_addr    = '0;
        w_sel_wr_data = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx     = c_PTR_W'(i);
                w_sel_wr_en   = m_wr_en[i];
                w_sel_rd_en   = m_rd_en[i];
                w_sel_addr    = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wr_data = m_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_ptr_nxt  = (w_gnt_idx == c_PTR_W'(N_MASTER - 1)) ? '0 : w_gnt_idx + c_PTR_W'(1);
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_cnt == c_TO_LAST);
    assign w_ack_done = |(r_gnt & m_ack_rdy);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|w_gnt)     w_state_nxt = ST_REQ;
            ST_REQ:  if (s_req_rdy)  w_state_nxt = ST_WAIT;
            ST_WAIT: if (s_ack_vld || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP: if (w_ack_done) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A real ack takes precedence over expiry in the same cycle
    always_ff @(posedge clk) begin
        if (srst) begin
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_rd_data <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_gnt     <= w_gnt;
                        r_wr_en   <= w_sel_wr_en;
                        r_rd_en   <= w_sel_rd_en;
                        r_addr    <= w_sel_addr;
                        r_wr_data <= w_sel_wr_data;
                        r_ptr     <= w_ptr_nxt;
                    end
                end
                ST_REQ: begin
                    if (s_req_rdy) begin
                        r_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (s_ack_vld) begin
                        r_rd_data <= s_rd_data;
                        r_err     <= 1'b0;
                    end else if (w_timeout) begin
                        r_rd_data <= TIMEOUT_DATA;
                        r_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_req_rdy = w_gnt;
    assign m_ack_vld = (r_state == ST_RESP) ? r_gnt : '0;
    assign m_rd_data = r_rd_data;
    assign m_err     = r_err;
    assign s_req_vld = (r_state == ST_REQ);
    assign s_ack_rdy = (r_state == ST_WAIT);
    assign s_wr_en   = r_wr_en;
    assign s_rd_en   = r_rd_en;
    assign s_addr    = r_addr;
    assign s_wr_data = r_wr_data;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_reg_native_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_native_arb
//  Description : Directed self-checking bench for reg_native_arb (N=3, timeout 8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_native_arb;

    localparam int N  = 3;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              srst;
    logic [N-1:0]      m_req_vld;
    logic [N-1:0]      m_req_rdy;
    logic [N-1:0]      m_wr_en;
    logic [N-1:0]      m_rd_en;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wr_data;
    logic [N-1:0]      m_ack_vld;
    logic [N-1:0]      m_ack_rdy;
    logic [DW-1:0]     m_rd_data;
    logic              m_err;
    logic              s_req_vld;
    logic              s_req_rdy;
    logic              s_wr_en;
    logic              s_rd_en;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wr_data;
    logic              s_ack_vld;
    logic              s_ack_rdy;
    logic [DW-1:0]     s_rd_data;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_native_arb #(
        .N_MASTER       (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .m_req_vld (m_req_vld),
        .m_req_rdy (m_req_rdy),
        .m_wr_en   (m_wr_en),
        .m_rd_en   (m_rd_en),
        .m_addr    (m_addr),
        .m_wr_data (m_wr_data),
        .m_ack_vld (m_ack_vld),
        .m_ack_rdy (m_ack_rdy),
        .m_rd_data (m_rd_data),
        .m_err     (m_err),
        .s_req_vld (s_req_vld),
        .s_req_rdy (s_req_rdy),
        .s_wr_en   (s_wr_en),
        .s_rd_en   (s_rd_en),
        .s_addr    (s_addr),
        .s_wr_data (s_wr_data),
        .s_ack_vld (s_ack_vld),
        .s_ack_rdy (s_ack_rdy),
        .s_rd_data (s_rd_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic wr, input logic rd,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
        m_wr_en[i]             = wr;
        m_rd_en[i]             = rd;
        m_addr[i*AW +: AW]     = addr;
        m_wr_data[i*DW +: DW]  = data;
    endtask

    initial begin
        int          exp_seq [6];
        int          ng;
        int          last;
        logic [N-1:0] pending;
        logic [N-1:0] rdy_s;
        logic [DW-1:0] held_data;

        exp_seq = '{0, 1, 2, 0, 1, 2};
        srst = 1'b1; m_req_vld = '0; m_wr_en = '0; m_rd_en = '0;
        m_addr = '0; m_wr_data = '0; m_ack_rdy = '0;
        s_req_rdy = 1'b0; s_ack_vld = 1'b0; s_rd_data = '0;
        tick(); tick();

        chk("rst_busy",      busy,      0);
        chk("rst_req_rdy",   m_req_rdy, 0);
        chk("rst_ack_vld",   m_ack_vld, 0);
        chk("rst_s_req_vld", s_req_vld, 0);
        chk("rst_s_ack_rdy", s_ack_rdy, 0);
        chk("rst_rd_data",   m_rd_data, 0);
        chk("rst_err",       m_err,     0);
        chk("rst_s_addr",    s_addr,    0);

        // ---------------- single write, master 1 ----------------
        srst = 1'b0;
        s_req_rdy = 1'b1; s_ack_vld = 1'b1; s_rd_data = 32'h0BAD_0BAD; m_ack_rdy = 3'b111;
        set_cmd(1, 1'b1, 1'b0, 64'h200, 32'hFFFF_FFFF);
        m_req_vld = 3'b010;
        #1;
        chk("wr_req_rdy", m_req_rdy, 3'b010);
        tick();
        m_req_vld = '0;
        chk("wr_s_req_vld", s_req_vld, 1);
        chk("wr_s_addr",    s_addr,    64'h200);
        chk("wr_s_wdata",   s_wr_data, 32'hFFFF_FFFF);
        chk("wr_s_cmd",     {s_wr_en, s_rd_en}, 2'b10);
        chk("wr_busy",      busy, 1);
        tick();
        chk("wr_s_ack_rdy", s_ack_rdy, 1);
        chk("wr_no_ack_yet", m_ack_vld, 0);
        tick();
        chk("wr_ack_vld",   m_ack_vld, 3'b010);
        chk("wr_err",       m_err, 0);
        tick();
        chk("wr_busy_drop", busy, 0);
        chk("wr_ack_drop",  m_ack_vld, 0);

        // ---------------- round robin over all three ----------------
        srst = 1'b1; tick(); srst = 1'b0;
        for (int i = 0; i < N; i++) begin
            set_cmd(i, 1'b1, 1'b0, 64'(32'h1000 * (i + 1)), 32'(i + 32'hA0));
        end
        ng = 0; last = 0; pending = 3'b111;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            m_req_vld = pending;
            #1;
            rdy_s = m_req_rdy;
            chk("rr_rdy_onehot0", 64'($onehot0(m_req_rdy)), 1);
            chk("rr_ack_onehot0", 64'($onehot0(m_ack_vld)), 1);
            if (m_ack_vld != '0) chk("rr_ack_route", m_ack_vld, 64'(1) << last);
            if (s_req_vld) chk("rr_s_addr", s_addr, 64'(32'h1000 * (last + 1)));
            if (rdy_s != '0) begin
                chk("rr_grant", rdy_s, 64'(1) << exp_seq[ng]);
                last = exp_seq[ng];
                ng++;
            end
            tick();
            pending = pending & ~rdy_s;
            if (ng == 3 && pending == '0) pending = 3'b111;
        end
        chk("rr_grant_count", ng, 6);
        m_req_vld = '0;
        for (int c = 0; c < 4; c++) tick();
        chk("rr_idle_after", busy, 0);

        // ---------------- read with delayed ack + backpressure ----------------
        m_ack_rdy = '0; s_ack_vld = 1'b0; s_rd_data = 32'h5555_AAAA;
        set_cmd(0, 1'b0, 1'b1, 64'h40, 32'h0);
        m_req_vld = 3'b001;
        #1;
        chk("rd_req_rdy", m_req_rdy, 3'b001);
        tick();
        m_req_vld = '0;
        chk("rd_s_cmd", {s_wr_en, s_rd_en}, 2'b01);
        tick();
        for (int c = 0; c < 4; c++) begin
            chk("rd_wait_ack_rdy", s_ack_rdy, 1);
            chk("rd_wait_no_ack",  m_ack_vld, 0);
            tick();
        end
        s_ack_vld = 1'b1; s_rd_data = 32'h1234_5678;
        tick();
        s_ack_vld = 1'b0; s_rd_data = 32'h0;
        chk("rd_ack_vld", m_ack_vld, 3'b001);
        chk("rd_data",    m_rd_data, 32'h1234_5678);
        chk("rd_err",     m_err, 0);
        held_data = m_rd_data;
        set_cmd(2, 1'b1, 1'b0, 64'h300, 32'h0000_0077);
        m_req_vld = 3'b100;
        m_ack_rdy = 3'b110;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_ack_stable",  m_ack_vld, 3'b001);
            chk("bp_data_stable", m_rd_data, held_data);
            chk("bp_no_req_rdy",  m_req_rdy, 0);
            tick();
        end
        m_ack_rdy = 3'b001;
        tick();
        m_ack_rdy = '0;
        chk("bp_busy_drop", busy, 0);

        // ---------------- timeout, slave never acks ----------------
        #1;
        chk("to_req_rdy", m_req_rdy, 3'b100);
        tick();
        m_req_vld = '0;
        tick();
        for (int c = 1; c <= TO; c++) begin
            chk("to_wait_ack_rdy", s_ack_rdy, 1);
            chk("to_wait_no_ack",  m_ack_vld, 0);
            tick();
        end
        chk("to_ack_vld",   m_ack_vld, 3'b100);
        chk("to_rd_data",   m_rd_data, 32'hDEAD_BEEF);
        chk("to_err",       m_err, 1);
        s_ack_vld = 1'b1;
        #1;
        chk("to_late_ack_rdy", s_ack_rdy, 0);
        s_ack_vld = 1'b0;
        m_ack_rdy = 3'b100;
        tick();
        m_ack_rdy = '0;
        chk("to_busy_drop", busy, 0);

        // ---------------- ack on the expiry cycle ----------------
        set_cmd(0, 1'b0, 1'b1, 64'h80, 32'h0);
        m_req_vld = 3'b001;
        #1;
        chk("tx_req_rdy", m_req_rdy, 3'b001);
        tick();
        m_req_vld = '0;
        tick();
        for (int c = 1; c < TO; c++) tick();
        chk("tx_still_wait", s_ack_rdy, 1);
        s_ack_vld = 1'b1; s_rd_data = 32'hCAFE_0001;
        tick();
        s_ack_vld = 1'b0;
        chk("tx_ack_vld", m_ack_vld, 3'b001);
        chk("tx_rd_data", m_rd_data, 32'hCAFE_0001);
        chk("tx_err",     m_err, 0);
        m_ack_rdy = 3'b001;
        tick();
        m_ack_rdy = '0;

        // ---------------- reset during WAIT ----------------
        set_cmd(1, 1'b0, 1'b1, 64'h44, 32'h0);
        m_req_vld = 3'b010;
        #1;
        chk("sr_req_rdy", m_req_rdy, 3'b010);
        tick();
        m_req_vld = '0;
        tick();
        tick();
        chk("sr_in_wait", s_ack_rdy, 1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("sr_busy",      busy, 0);
        chk("sr_s_ack_rdy", s_ack_rdy, 0);
        chk("sr_no_ack",    m_ack_vld, 0);
        chk("sr_rd_data",   m_rd_data, 0);
        tick();
        chk("sr_no_ack_2",  m_ack_vld, 0);

        s_ack_vld = 1'b1; s_rd_data = 32'h0000_BEEF; m_ack_rdy = 3'b010;
        m_req_vld = 3'b010;
        #1;
        chk("sr2_req_rdy", m_req_rdy, 3'b010);
        tick();
        m_req_vld = '0;
        tick();
        tick();
        chk("sr2_ack_vld", m_ack_vld, 3'b010);
        chk("sr2_rd_data", m_rd_data, 32'h0000_BEEF);
        tick();
        chk("sr2_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
